// File: rtl/trng_sample_ctrl.sv
// TRNG sample controller: warms up the ring generator, decimates its state,
// health-checks captured words and hands them out over valid/ready.
module trng_sample_ctrl #(
  parameter int WARMUP_CYCLES = 64,
  parameter int DECIM_CYCLES  = 32,
  parameter int REP_LIMIT     = 2,
  parameter int CNT_W         = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic        i_clr,
  input  logic [31:0] i_rg_data,
  output logic        o_rg_rst,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_data,
  output logic        o_busy,
  output logic        o_fail
);

  localparam int REP_W = $clog2(REP_LIMIT + 1);
  localparam logic [CNT_W-1:0] WARM_LD = CNT_W'(WARMUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEC_LD  = CNT_W'(DECIM_CYCLES - 1);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REP_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WARMUP,
    S_DECIM,
    S_OUTPUT,
    S_FAIL
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [REP_W-1:0] rep_inc;
  logic [31:0]      prev_q, prev_d;
  logic             pvld_q, pvld_d;
  logic             valid_d;
  logic [31:0]      data_d;
  logic             rg_rst_d;
  logic             busy_d;
  logic             fail_d;
  logic             same;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rep_q    <= '0;
      prev_q   <= '0;
      pvld_q   <= 1'b0;
      o_valid  <= 1'b0;
      o_data   <= '0;
      o_rg_rst <= 1'b1;
      o_busy   <= 1'b0;
      o_fail   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rep_q    <= rep_d;
      prev_q   <= prev_d;
      pvld_q   <= pvld_d;
      o_valid  <= valid_d;
      o_data   <= data_d;
      o_rg_rst <= rg_rst_d;
      o_busy   <= busy_d;
      o_fail   <= fail_d;
    end
  end

  assign rep_inc = rep_q + 1'b1;
  assign same    = pvld_q && (i_rg_data == prev_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    prev_d  = prev_q;
    pvld_d  = pvld_q;
    valid_d = o_valid;
    data_d  = o_data;
    unique case (state_q)
      S_IDLE: begin
        pvld_d = 1'b0;
        rep_d  = '0;
        if (i_en) begin
          state_d = S_WARMUP;
          cnt_d   = WARM_LD;
        end
      end
      S_WARMUP: begin
        if (!i_en) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_DECIM;
          cnt_d   = DEC_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DECIM: begin
        if (!i_en) begin
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // Failing words never reach o_data.
          unique case (1'b1)
            (i_rg_data == '0): state_d = S_FAIL;
            (same && rep_inc == REP_MAX): state_d = S_FAIL;
            default: begin
              rep_d   = same ? rep_inc : '0;
              prev_d  = i_rg_data;
              pvld_d  = 1'b1;
              data_d  = i_rg_data;
              valid_d = 1'b1;
              state_d = S_OUTPUT;
            end
          endcase
        end
      end
      S_OUTPUT: begin
        if (i_ready) begin
          valid_d = 1'b0;
          if (i_en) begin
            state_d = S_DECIM;
            cnt_d   = DEC_LD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_FAIL: begin
        if (i_clr) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they track it exactly.
  always_comb begin
    rg_rst_d = (state_d == S_IDLE) || (state_d == S_FAIL);
    busy_d   = (state_d == S_WARMUP) || (state_d == S_DECIM) ||
               (state_d == S_OUTPUT);
    fail_d   = (state_d == S_FAIL);
  end

endmodule

// File: tb/tb_trng_sample_ctrl.sv
// Bench for trng_sample_ctrl: directed scenarios plus random traffic
// checked against a transaction-level reference model.
module tb_trng_sample_ctrl;

  localparam int W  = 4;
  localparam int D  = 2;
  localparam int RL = 2;

  localparam int M_IDLE = 0;
  localparam int M_WARM = 1;
  localparam int M_DEC  = 2;
  localparam int M_OUT  = 3;
  localparam int M_FAIL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        clr;
  logic        ready;
  logic [31:0] rg;
  logic        rg_rst;
  logic        valid;
  logic [31:0] data;
  logic        busy;
  logic        fail;

  always #5 clk = ~clk;

  trng_sample_ctrl #(
    .WARMUP_CYCLES(W),
    .DECIM_CYCLES (D),
    .REP_LIMIT    (RL),
    .CNT_W        (8)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_en     (en),
    .i_clr    (clr),
    .i_rg_data(rg),
    .o_rg_rst (rg_rst),
    .o_valid  (valid),
    .i_ready  (ready),
    .o_data   (data),
    .o_busy   (busy),
    .o_fail   (fail)
  );

  int          checks = 0;
  int          errors = 0;
  int          mode;
  int          now;
  int          deadline;
  logic [31:0] mdata;
  logic [31:0] seen[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int run_len(input logic [31:0] w);
    int n = 0;
    for (int i = seen.size() - 1; i >= 0; i--) begin
      if (seen[i] != w) break;
      n++;
    end
    return n;
  endfunction

  task automatic model_reset();
    mode  = M_IDLE;
    mdata = '0;
    seen.delete();
  endtask

  // Advance the model by one cycle using the inputs about to be sampled.
  task automatic model_step();
    case (mode)
      M_IDLE: begin
        seen.delete();
        if (en) begin
          mode     = M_WARM;
          deadline = now + W;
        end
      end
      M_WARM: begin
        if (!en) mode = M_IDLE;
        else if (now == deadline) begin
          mode     = M_DEC;
          deadline = now + D;
        end
      end
      M_DEC: begin
        if (!en) mode = M_IDLE;
        else if (now == deadline) begin
          if (rg == 0 || run_len(rg) >= RL) mode = M_FAIL;
          else begin
            seen.push_back(rg);
            mdata = rg;
            mode  = M_OUT;
          end
        end
      end
      M_OUT: begin
        if (ready) begin
          if (en) begin
            mode     = M_DEC;
            deadline = now + D;
          end else mode = M_IDLE;
        end
      end
      M_FAIL: if (clr) mode = M_IDLE;
      default: mode = M_IDLE;
    endcase
  endtask

  task automatic check_model();
    chk("m_valid", 32'(valid), 32'(mode == M_OUT));
    chk("m_data", data, mdata);
    chk("m_rgrst", 32'(rg_rst), 32'(mode == M_IDLE || mode == M_FAIL));
    chk("m_busy", 32'(busy),
        32'(mode == M_WARM || mode == M_DEC || mode == M_OUT));
    chk("m_fail", 32'(fail), 32'(mode == M_FAIL));
  endtask

  task automatic step(input logic e, input logic r, input logic c,
                      input logic [31:0] d);
    en    = e;
    ready = r;
    clr   = c;
    rg    = d;
    model_step();
    @(posedge clk);
    #1;
    now++;
    check_model();
  endtask

  task automatic wait_valid(input string tag, input logic e,
                            input logic [31:0] d);
    for (int i = 0; i < 40; i++) begin
      step(e, 1'b0, 1'b0, d);
      if (valid) break;
    end
    chk(tag, 32'(valid), 32'd1);
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] word;
    int          nv;
    rst   = 1'b1;
    en    = 1'b0;
    clr   = 1'b0;
    ready = 1'b0;
    rg    = '0;
    now   = 0;
    deadline = 0;
    model_reset();
    #3;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_rgrst", 32'(rg_rst), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fail", 32'(fail), 32'd0);
    #9 rst = 1'b0;
    @(posedge clk);
    #1;
    check_model();

    // Basic timing with data equal to the cycle index.
    for (int k = 0; k < 12; k++) begin
      step(1'b1, 1'b1, 1'b0, 32'(k));
      if (k == 0) chk("t1_rgrst", 32'(rg_rst), 32'd0);
      if (k == 5) chk("t1_novalid6", 32'(valid), 32'd0);
      if (k == 6) begin
        chk("t1_valid7", 32'(valid), 32'd1);
        chk("t1_data7", data, 32'd6);
      end
      if (k == 8) chk("t1_novalid9", 32'(valid), 32'd0);
      if (k == 9) begin
        chk("t1_valid10", 32'(valid), 32'd1);
        chk("t1_data10", data, 32'd9);
      end
    end
    step(1'b0, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0);

    // Backpressure.
    wait_valid("t2_reach", 1'b1, $urandom | 32'd1);
    v = mdata;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0, $urandom | 32'd1);
      chk("t2_hold_v", 32'(valid), 32'd1);
      chk("t2_hold_d", data, v);
    end
    step(1'b1, 1'b1, 1'b0, $urandom | 32'd1);
    chk("t2_hs_drop", 32'(valid), 32'd0);
    for (int j = 1; j <= D; j++) begin
      step(1'b1, 1'b0, 1'b0, $urandom | 32'd1);
      chk("t2_next", 32'(valid), 32'(j == D));
    end
    step(1'b0, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0);

    // Repetition-count failure.
    nv = 0;
    for (int i = 0; i < 60; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'hA5A5A5A5);
      if (valid) nv++;
      if (fail) break;
    end
    chk("t3_words", 32'(nv), 32'd2);
    chk("t3_fail", 32'(fail), 32'd1);
    chk("t3_rgrst", 32'(rg_rst), 32'd1);
    chk("t3_valid", 32'(valid), 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'hA5A5A5A5);
    chk("t3_sticky", 32'(fail), 32'd1);
    step(1'b0, 1'b0, 1'b1, 32'd0);
    chk("t3_clr", 32'(fail), 32'd0);
    chk("t3_clr_busy", 32'(busy), 32'd0);

    // Zero-word failure.
    nv = 0;
    for (int i = 0; i < 60; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'd0);
      if (valid) nv++;
      if (fail) break;
    end
    chk("t4_words", 32'(nv), 32'd0);
    chk("t4_fail", 32'(fail), 32'd1);
    for (int i = 0; i < 6; i++) begin
      step(1'(i % 2), 1'b1, 1'b0, 32'd0);
      chk("t4_sticky", 32'(fail), 32'd1);
      chk("t4_novalid", 32'(valid), 32'd0);
    end
    step(1'b0, 1'b0, 1'b1, 32'd0);

    // Aborts in WARMUP and OUTPUT.
    step(1'b1, 1'b1, 1'b0, 32'h1234);
    step(1'b1, 1'b1, 1'b0, 32'h1234);
    step(1'b0, 1'b1, 1'b0, 32'h1234);
    chk("t5_warm_abort", 32'(rg_rst), 32'd1);
    chk("t5_warm_busy", 32'(busy), 32'd0);
    wait_valid("t5_reach", 1'b1, 32'h5678);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h9abc);
      chk("t5_out_hold", 32'(valid), 32'd1);
    end
    step(1'b0, 1'b1, 1'b0, 32'h9abc);
    chk("t5_out_idle", 32'(busy), 32'd0);
    chk("t5_out_rgrst", 32'(rg_rst), 32'd1);

    // Random traffic.
    word = $urandom | 32'd1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) word = $urandom | 32'd1;
      if ($urandom_range(0, 60) == 0) word = 32'd0;
      step($urandom_range(0, 9) != 0, 1'($urandom), $urandom_range(0, 15) == 0,
           word);
    end

    // Asynchronous reset during OUTPUT.
    step(1'b0, 1'b1, 1'b1, 32'd0);
    step(1'b0, 1'b1, 1'b1, 32'd0);
    wait_valid("t6_reach", 1'b1, 32'hCAFE0001);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("t6_valid", 32'(valid), 32'd0);
    chk("t6_data", data, 32'd0);
    chk("t6_rgrst", 32'(rg_rst), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);
    #3 rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'd7);
    chk("t6_restart", 32'(rg_rst), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
